// File: rtl/cam_idx.sv
// Registered key-to-index lookup: NR writable keyed entries, valid/ready search
// port returning the 1-based index of the lowest matching valid entry (0 = miss).
module cam_idx #(
  parameter int NR = 4,
  parameter int KW = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [KW-1:0] req_key,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [IW-1:0] resp_idx,
  output logic          resp_hit,
  output logic          resp_multi,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [KW-1:0] wr_key,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_idx,
  input  logic          flush,
  output logic [IW-1:0] count,
  output logic          full
);

  logic [NR-1:0] valid_q, valid_d;
  logic [KW-1:0] key_q [NR];
  logic [KW-1:0] key_d [NR];
  logic [IW-1:0] count_q, count_d;

  logic          resp_valid_q;
  logic [IW-1:0] resp_idx_q, resp_idx_d;
  logic          resp_hit_q;
  logic          resp_multi_q, resp_multi_d;

  logic [NR-1:0] match;
  logic          fire;

  function automatic logic [IW-1:0] popcnt(input logic [NR-1:0] v);
    logic [IW-1:0] n;
    n = '0;
    for (int i = 0; i < NR; i++) n = n + IW'(v[i]);
    return n;
  endfunction

  assign req_ready = !resp_valid_q || resp_ready;
  assign fire      = req_valid && req_ready;

  // Search path sees only pre-edge contents, so same-cycle updates stay invisible.
  always_comb begin
    match      = '0;
    resp_idx_d = '0;
    for (int i = 0; i < NR; i++) match[i] = valid_q[i] && (key_q[i] == req_key);
    for (int i = NR - 1; i >= 0; i--) begin
      if (match[i]) resp_idx_d = IW'(i + 1);
    end
    resp_multi_d = popcnt(match) > IW'(1);
  end

  // Later assignments win: flush < clear < write. Out-of-range indices match no entry.
  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    if (flush) valid_d = '0;
    for (int i = 0; i < NR; i++) begin
      if (clr_en && clr_idx == IW'(i)) valid_d[i] = 1'b0;
      if (wr_en && wr_idx == IW'(i)) begin
        valid_d[i] = 1'b1;
        key_d[i]   = wr_key;
      end
    end
    count_d = popcnt(valid_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      for (int i = 0; i < NR; i++) key_q[i] <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_hit_q   <= 1'b0;
      resp_multi_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      key_q   <= key_d;
      count_q <= count_d;
      if (fire) begin
        resp_valid_q <= 1'b1;
        resp_idx_q   <= resp_idx_d;
        resp_hit_q   <= (resp_idx_d != '0);
        resp_multi_q <= resp_multi_d;
      end else if (resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_idx   = resp_idx_q;
  assign resp_hit   = resp_hit_q;
  assign resp_multi = resp_multi_q;
  assign count      = count_q;
  assign full       = (count_q == IW'(NR));

endmodule
